// File: rtl/lsu_pkg.sv
// Shared types and default sizing for the load/store unit.
package lsu_pkg;

  localparam int LSU_DATA_W    = 24;
  localparam int LSU_MEM_DEPTH = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_req_fifo.sv
// Two-entry in-order request FIFO; head is visible combinationally on dout.
// A push when full is ignored; a push and a pop together leave count unchanged.
module lsu_req_fifo #(
  parameter int W = 49
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: queues requests, performs one memory access per request, returns one response each.
// Response 2 cycles after acceptance when idle; response fields hold while rsp_ready is low.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_W    = LSU_DATA_W,
  parameter int MEM_DEPTH = LSU_MEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_we,
  output logic              rsp_err,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [7:0]        err_cnt
);

  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  localparam int REQ_W = $bits(req_t);

  req_t              fifo_din, fifo_dout;
  req_t              cur_q, cur_d;
  lsu_state_e        state_q, state_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_we_q, rsp_we_d;
  logic              rsp_err_q, rsp_err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [1:0]        fifo_count;
  logic              in_range;

  assign fifo_din  = '{we: req_we, addr: req_addr, wdata: req_wdata};
  assign fifo_push = req_valid && !fifo_full;
  assign req_ready = (fifo_count < 2'd2);
  assign in_range  = (cur_q.addr < DATA_W'(MEM_DEPTH));

  lsu_req_fifo #(.W(REQ_W)) u_req_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_we_d    = rsp_we_q;
    rsp_err_d   = rsp_err_q;
    err_cnt_d   = err_cnt_q;
    fifo_pop    = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_din     = '0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cur_d    = fifo_dout;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        mem_addr    = cur_q.addr;
        mem_din     = cur_q.wdata;
        // Reset gates the write so an in-flight store never commits during the reset cycle.
        mem_we      = cur_q.we && in_range && rst_n;
        rsp_we_d    = cur_q.we;
        rsp_err_d   = !in_range;
        rsp_rdata_d = (!cur_q.we && in_range) ? mem_dout : '0;
        if (!in_range && err_cnt_q != 8'hFF) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            cur_d    = fifo_dout;
            state_d  = ACCESS;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_we_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_we_q    <= rsp_we_d;
      rsp_err_q   <= rsp_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_we    = rsp_we_q;
  assign rsp_err   = rsp_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters SHALL be:
- DATA_W, default 24, data and address width.
- MEM_DEPTH, default 256, number of valid memory words.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, clock.
- rst_n, in, 1, reset, synchronous, active-low.
- req_valid, in, 1, request offered.
- req_ready, out, 1, request can be accepted.
- req_we, in, 1, 1 = store, 0 = load.
- req_addr, in, DATA_W, word address.
- req_wdata, in, DATA_W, store data.
- rsp_valid, out, 1, response offered.
- rsp_ready, in, 1, response consumed.
- rsp_rdata, out, DATA_W, load data (0 for stores and errors).
- rsp_we, out, 1, echo of req_we.
- rsp_err, out, 1, address out of range.
- mem_addr, out, DATA_W, address to memory.
- mem_din, out, DATA_W, write data to memory.
- mem_we, out, 1, memory write enable.
- mem_dout, in, DATA_W, combinational read data from memory.
- err_cnt, out, 8, saturating error count.

Function
REQ-003 Request transfer SHALL occur on a rising clk edge with req_valid=1 and req_ready=1; {req_we, req_addr, req_wdata} SHALL be pushed into a 2-entry in-order FIFO.
REQ-004 req_ready SHALL equal (FIFO count < 2), with no combinational path from rsp_ready or req_valid.
REQ-005 The FSM SHALL have states IDLE, ACCESS and RESP:
- IDLE -> ACCESS when the FIFO is non-empty, popping the head.
- ACCESS -> RESP unconditionally.
- RESP -> ACCESS (pop) when rsp_ready=1 and the FIFO is non-empty.
- RESP -> IDLE when rsp_ready=1 and the FIFO is empty.
- RESP holds otherwise.
REQ-006 In ACCESS, mem_addr SHALL be the popped address, mem_din the popped data, and mem_we = req_we AND (addr < MEM_DEPTH); outside ACCESS, mem_we, mem_addr and mem_din SHALL be 0.
REQ-007 In ACCESS, a load SHALL register mem_dout into rsp_rdata; a store or an out-of-range load SHALL register 0.
REQ-008 rsp_valid SHALL be 1 exactly in RESP; rsp_rdata, rsp_we and rsp_err SHALL remain stable while rsp_valid=1 and rsp_ready=0.
REQ-009 Latency from the acceptance edge to rsp_valid=1 SHALL be 2 cycles when idle; sustained throughput SHALL be 1 request per 2 cycles with rsp_ready held at 1.
REQ-010 Every accepted request SHALL produce exactly one response, in acceptance order.
REQ-011 An address >= MEM_DEPTH SHALL set rsp_err=1, SHALL never assert mem_war, and SHALL still produce a response.
REQ-012 err_cnt SHALL increment by 1 at the ACCESS cycle of each error, saturating at 255.
REQ-013 A push and a pop on the same edge SHALL leave the FIFO count unchanged; a push when full SHALL NOT be possible.
REQ-014 Store-then-load to the same address SHALL return the stored value, since the write commits at the end of the store's ACCESS cycle.

Reset
REQ-015 While rst_n=0 at a clk edge, the block SHALL:
- set the FSM to IDLE and flush the FIFO;
- drive rsp_valid, rsp_rdata, rsp_we, rsp_err, mem_we, mem_addr, mem_din and err_cnt to 0;
- drive req_ready to 1 from the first cycle after reset.
REQ-016 Reset mid-operation SHALL discard all pending and in-flight requests and responses, and SHALL NOT assert mem_we in the reset cycle.

Structure
REQ-017 A shared package lsu_pkg SHALL hold the FSM state enum (IDLE, ACCESS, RESP) and the DATA_W/MEM_DEPTH defaults.
REQ-018 The FIFO SHALL be a sub-module lsu_req_fifo (2 entries, push/pop, count, full/empty); the FSM and datapath SHALL reside in load_store_unit.

Verification
REQ-019 Store 0x00ABCD to addr 5, then load addr 5 with rsp_ready=1 -> one store response (rdata 0, we 1, err 0), then load rsp_rdata=0x00ABCD; mem_we high for exactly 1 cycle.
REQ-020 Back-to-back loads to addrs 1, 2, 3 with rsp_ready=1 -> req_ready drops after 2 are queued; responses in order 1, 2, 3; rsp_valid 2 cycles after the first acceptance.
REQ-021 Load addr 0x000100 (256) -> rsp_err=1, rsp_rdata=0, mem_we never 1, err_cnt=1; 300 such requests -> err_cnt=255.
REQ-022 Hold rsp_ready=0 for 10 cycles during a response -> rsp_valid and the response fields stable; the FIFO fills to 2 and req_ready=0; release -> all three responses delivered in order.
REQ-023 Assert rst_n=0 with one request in ACCESS and one in the FIFO -> next cycle rsp_valid=0, mem_we=0, req_ready=1, and no stale response ever appears.
